div_ctrl: RTL and testbench

- Sequencing controller and iterative radix-2 restoring divider behind the ALU's divide interface.
- Accepts a start request with operands and a divide sub-op from the execute stage.
- Runs the shift-subtract loop, applies RISC-V M-extension sign and corner-case rules, and returns a one-cycle ready pulse with the result.
- While the ALU holds div_start asserted and waits for ready, the ALU reports busy and the pipeline stalls.

---
 rtl/div_if.sv | 24 ++
 rtl/div_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Divide request/response bundle between the ALU execute stage and div_ctrl.
// The ALU drives the master side and the divider implements the slave side.
interface div_if #(
   parameter int CPU_WIDTH = 32
);
   logic                 div_start_i;
   logic [1:0]           div_op_i;
   logic [CPU_WIDTH-1:0] dividend_i;
   logic [CPU_WIDTH-1:0] divisor_i;
   logic                 flush_i;
   logic [CPU_WIDTH-1:0] div_result_o;
   logic                 div_res_ready_o;
   logic                 div_busy_o;

   modport master (
      output div_start_i, div_op_i, dividend_i, divisor_i, flush_i,
      input  div_result_o, div_res_ready_o, div_busy_o
   );

   modport slave (
      input  div_start_i, div_op_i, dividend_i, divisor_i, flush_i,
      output div_result_o, div_res_ready_o, div_busy_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider with RISC-V M-extension sign and corner-case rules.
// Optional DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module div_ctrl #(
   parameter int CPU_WIDTH = 32,
   parameter int CNT_WIDTH = 6
) (
   input logic clk,
   input logic rst,
   div_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [CPU_WIDTH-1:0] rem_r, rem_s;
   logic [CPU_WIDTH-1:0] quo_r, quo_s;
   logic [CPU_WIDTH-1:0] dvs_r, dvs_s;
   logic [CPU_WIDTH-1:0] result_r, result_s;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
   logic                 is_rem_r, is_rem_s;
   logic                 quo_neg_r, quo_neg_s;
   logic                 rem_neg_r, rem_neg_s;
   logic                 ready_r, ready_s;
   logic                 busy_r, busy_s;

   logic                 op_signed_s;
   logic                 div_zero_s;
   logic                 ovf_s;
   logic                 early_s;
   logic [CPU_WIDTH-1:0] mag_a_s, mag_b_s;
   logic [CPU_WIDTH-1:0] special_res_s;
   logic [CPU_WIDTH:0]   rem_sh_s, diff_s;

   function automatic logic [CPU_WIDTH-1:0] neg_if(input logic [CPU_WIDTH-1:0] v,
                                                   input logic en);
      return en ? (~v + {{(CPU_WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Operand decode: magnitudes and the cases that bypass the iteration loop.
   always_comb begin
      op_signed_s = ~bus.div_op_i[0];
      mag_a_s     = neg_if(bus.dividend_i, op_signed_s & bus.dividend_i[CPU_WIDTH-1]);
      mag_b_s     = neg_if(bus.divisor_i,  op_signed_s & bus.divisor_i[CPU_WIDTH-1]);
      div_zero_s  = (bus.divisor_i == {CPU_WIDTH{1'b0}});
      ovf_s       = op_signed_s
                    & (bus.dividend_i == {1'b1, {(CPU_WIDTH-1){1'b0}}})
                    & (bus.divisor_i  == {CPU_WIDTH{1'b1}});
`ifdef DIV_EARLY_OUT_EN
      early_s     = ~div_zero_s & (mag_a_s < mag_b_s);
`else
      early_s     = 1'b0;
`endif
      if (div_zero_s) begin
         special_res_s = bus.div_op_i[1] ? bus.dividend_i : {CPU_WIDTH{1'b1}};
      end else if (ovf_s) begin
         special_res_s = bus.div_op_i[1] ? {CPU_WIDTH{1'b0}} : bus.dividend_i;
      end else begin
         special_res_s = bus.div_op_i[1] ? bus.dividend_i : {CPU_WIDTH{1'b0}};
      end
   end

   // Trial subtraction: the shifted remainder needs one extra bit so the borrow survives.
   always_comb begin
      rem_sh_s = {rem_r, quo_r[CPU_WIDTH-1]};
      diff_s   = rem_sh_s - {1'b0, dvs_r};
   end

   // Next-state and next-register logic for the controller and datapath.
   always_comb begin
      state_s   = state_r;
      rem_s     = rem_r;
      quo_s     = quo_r;
      dvs_s     = dvs_r;
      result_s  = result_r;
      cnt_s     = cnt_r;
      is_rem_s  = is_rem_r;
      quo_neg_s = quo_neg_r;
      rem_neg_s = rem_neg_r;
      ready_s   = 1'b0;
      busy_s    = busy_r;

      case (state_r)
         IDLE: begin
            result_s = {CPU_WIDTH{1'b0}};
            busy_s   = 1'b0;
            if (bus.div_start_i && !bus.flush_i) begin
               is_rem_s  = bus.div_op_i[1];
               quo_neg_s = op_signed_s & (bus.dividend_i[CPU_WIDTH-1] ^ bus.divisor_i[CPU_WIDTH-1]);
               rem_neg_s = op_signed_s & bus.dividend_i[CPU_WIDTH-1];
               quo_s     = mag_a_s;
               dvs_s     = mag_b_s;
               rem_s     = {CPU_WIDTH{1'b0}};
               cnt_s     = {CNT_WIDTH{1'b0}};
               busy_s    = 1'b1;
               if (div_zero_s || ovf_s || early_s) begin
                  result_s = special_res_s;
                  ready_s  = 1'b1;
                  state_s  = DONE;
               end else begin
                  state_s  = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            busy_s = 1'b1;
            if (!diff_s[CPU_WIDTH]) begin
               rem_s = diff_s[CPU_WIDTH-1:0];
               quo_s = {quo_r[CPU_WIDTH-2:0], 1'b1};
            end else begin
               rem_s = rem_sh_s[CPU_WIDTH-1:0];
               quo_s = {quo_r[CPU_WIDTH-2:0], 1'b0};
            end
            cnt_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_WIDTH'(CPU_WIDTH - 1)) begin
               state_s = FINAL;
            end else begin
               state_s = CALC;
            end
         end
         FINAL: begin
            busy_s   = 1'b1;
            ready_s  = 1'b1;
            result_s = is_rem_r ? neg_if(rem_r, rem_neg_r) : neg_if(quo_r, quo_neg_r);
            state_s  = DONE;
         end
         DONE: begin
            busy_s   = 1'b0;
            result_s = {CPU_WIDTH{1'b0}};
            state_s  = IDLE;
         end
         default: begin
            busy_s   = 1'b0;
            result_s = {CPU_WIDTH{1'b0}};
            state_s  = IDLE;
         end
      endcase

      // Flush wins over everything; a ready already on the wire in DONE is unaffected.
      if (bus.flush_i) begin
         state_s  = IDLE;
         busy_s   = 1'b0;
         ready_s  = 1'b0;
         result_s = {CPU_WIDTH{1'b0}};
      end else begin
         state_s  = state_s;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         rem_r     <= {CPU_WIDTH{1'b0}};
         quo_r     <= {CPU_WIDTH{1'b0}};
         dvs_r     <= {CPU_WIDTH{1'b0}};
         result_r  <= {CPU_WIDTH{1'b0}};
         cnt_r     <= {CNT_WIDTH{1'b0}};
         is_rem_r  <= 1'b0;
         quo_neg_r <= 1'b0;
         rem_neg_r <= 1'b0;
         ready_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         rem_r     <= rem_s;
         quo_r     <= quo_s;
         dvs_r     <= dvs_s;
         result_r  <= result_s;
         cnt_r     <= cnt_s;
         is_rem_r  <= is_rem_s;
         quo_neg_r <= quo_neg_s;
         rem_neg_r <= rem_neg_s;
         ready_r   <= ready_s;
         busy_r    <= busy_s;
      end
   end

   assign bus.div_result_o    = result_r;
   assign bus.div_res_ready_o = ready_r;
   assign bus.div_busy_o      = busy_r;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random operations
// compared against an arithmetic reference of the RISC-V divide rules.
module tb_div_ctrl;
   localparam int W    = 32;
   localparam int LAT  = W + 2;
   localparam int BOUND = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   div_if #(.CPU_WIDTH(W)) bus ();

   div_ctrl #(.CPU_WIDTH(W), .CNT_WIDTH(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] q, r;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      longint ma, mb;
      ma = op[0] ? longint'(a) : longint'($signed(a));
      mb = op[0] ? longint'(b) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return LAT;
   endfunction

   // Called just after a clock edge; that cycle is cycle 0 of the operation.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
      logic [W-1:0] exp_v;
      int           exp_lat;
      int           cyc;
      bit           seen;
      exp_v   = ref_div(op, a, b);
      exp_lat = ref_lat(op, a, b);
      bus.div_start_i = 1'b1;
      bus.div_op_i    = op;
      bus.dividend_i  = a;
      bus.divisor_i   = b;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < BOUND) begin
         tick();
         cyc++;
         bus.dividend_i = $urandom;
         bus.divisor_i  = $urandom;
         bus.div_op_i   = 2'($urandom_range(0, 3));
         if (bus.div_res_ready_o) begin
            seen = 1'b1;
            check({tag, " latency"}, cyc, exp_lat);
            check({tag, " result"}, bus.div_result_o, exp_v);
            check({tag, " busy@ready"}, bus.div_busy_o, 1);
            bus.div_start_i = 1'b0;
         end else if (cyc < exp_lat) begin
            check({tag, " busy"}, bus.div_busy_o, 1);
         end
      end
      check({tag, " ready seen"}, seen, 1);
      bus.div_start_i = 1'b0;
      tick();
      check({tag, " ready pulse"}, bus.div_res_ready_o, 0);
      check({tag, " idle busy"}, bus.div_busy_o, 0);
      check({tag, " result cleared"}, bus.div_result_o, 0);
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;

      bus.div_start_i = 1'b0;
      bus.div_op_i    = 2'b00;
      bus.dividend_i  = '0;
      bus.divisor_i   = '0;
      bus.flush_i     = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("reset result", bus.div_result_o, 0);
      check("reset ready", bus.div_res_ready_o, 0);
      check("reset busy", bus.div_busy_o, 0);
      rst = 1'b0;
      tick();

      run_op(2'b01, 32'd100, 32'd7, "divu 100/7");
      run_op(2'b11, 32'd100, 32'd7, "remu 100/7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem 7/-2");
      run_op(2'b01, 32'h1234, 32'd0, "divu by0");
      run_op(2'b11, 32'h1234, 32'd0, "remu by0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
      run_op(2'b01, 32'd5, 32'd9, "divu 5/9");
      run_op(2'b11, 32'd5, 32'd9, "remu 5/9");
      run_op(2'b00, 32'h8000_0000, 32'd1, "div min/1");

      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom; b = $urandom_range(1, 255); end
            2: begin a = $urandom; b = 0; end
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            4: begin a = $urandom_range(0, 100); b = $urandom_range(101, 100000); end
            default: begin a = $urandom; b = -($urandom_range(1, 1000)); end
         endcase
         run_op(op, a, b, $sformatf("rand%0d", i));
      end

      // Flush mid-operation.
      bus.div_start_i = 1'b1;
      bus.div_op_i    = 2'b01;
      bus.dividend_i  = 32'd1000;
      bus.divisor_i   = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         tick();
         check("flush pre busy", bus.div_busy_o, 1);
         check("flush pre ready", bus.div_res_ready_o, 0);
      end
      bus.flush_i     = 1'b1;
      bus.div_start_i = 1'b0;
      tick();
      check("flush busy", bus.div_busy_o, 0);
      check("flush ready", bus.div_res_ready_o, 0);
      bus.flush_i = 1'b0;
      tick();
      check("flush gap ready", bus.div_res_ready_o, 0);
      run_op(2'b01, 32'd9, 32'd3, "divu after flush");

      // Flush together with start: nothing accepted.
      bus.div_start_i = 1'b1;
      bus.flush_i     = 1'b1;
      bus.div_op_i    = 2'b01;
      bus.dividend_i  = 32'd50;
      bus.divisor_i   = 32'd0;
      tick();
      check("start+flush busy", bus.div_busy_o, 0);
      check("start+flush ready", bus.div_res_ready_o, 0);
      bus.div_start_i = 1'b0;
      bus.flush_i     = 1'b0;
      tick();

      // Reset mid-operation, start held through reset.
      bus.div_start_i = 1'b1;
      bus.div_op_i    = 2'b00;
      bus.dividend_i  = 32'd1000;
      bus.divisor_i   = 32'd3;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("rst pre busy", bus.div_busy_o, 1);
      end
      rst = 1'b1;
      tick();
      check("rst result", bus.div_result_o, 0);
      check("rst ready", bus.div_res_ready_o, 0);
      check("rst busy", bus.div_busy_o, 0);
      rst = 1'b0;
      run_op(2'b00, 32'd1000, 32'd3, "div after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
